// File: rtl/gcbp_stripe_gen.sv
// rtl/gcbp_stripe_gen.sv - bit-plane stripe generator for gray-code bit-plane sub images
//
// Scans one video line of luma samples, extracts one bit per pixel (binary or
// gray-coded bit plane k) and packs the pixels of each of C_NUM_SUBIMAGES
// windows into a C_SUBIMAGE_WIDTH-bit output line.
//
// Ports:
//   i_clk              clock, rising edge
//   i_resetn           synchronous active-low reset
//   i_luma_data        luma sample, qualified by i_luma_valid
//   i_luma_valid       one pixel consumed per cycle when high
//   i_new_line         single-cycle start-of-line pulse; latches plane/mode
//   i_bit_plane        bit plane k (clamped to C_LUMA_WIDTH-1)
//   i_gray_mode        1 = gray-coded bit plane
//   i_line_ready       consumer accepts o_line when high with o_line_valid
//   o_line             completed sub image line, first pixel at MSB
//   o_line_valid       o_line holds unconsumed data
//   o_subimage_idx     sub image index of o_line
//   o_busy             line scan in progress (GAP/CAPTURE)
//   o_overflow         one-cycle pulse when a pending o_line is overwritten
//   o_overflow_sticky  latched overflow, cleared only by reset
module gcbp_stripe_gen #(
  parameter int C_SUBIMAGE_WIDTH  = 128,
  parameter int C_NUM_SUBIMAGES   = 4,
  parameter int C_PIXELS_PER_LINE = 720,
  parameter int C_EDGE_GAP        = 41,
  parameter int C_INNER_GAP       = 42,
  parameter int C_LUMA_WIDTH      = 9
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic [C_LUMA_WIDTH-1:0]     i_luma_data,
  input  logic                        i_luma_valid,
  input  logic                        i_new_line,
  input  logic [3:0]                  i_bit_plane,
  input  logic                        i_gray_mode,
  input  logic                        i_line_ready,
  output logic [C_SUBIMAGE_WIDTH-1:0] o_line,
  output logic                        o_line_valid,
  output logic [2:0]                  o_subimage_idx,
  output logic                        o_busy,
  output logic                        o_overflow,
  output logic                        o_overflow_sticky
);

  localparam int W  = C_SUBIMAGE_WIDTH;
  localparam int CW = $clog2(C_PIXELS_PER_LINE + W + C_INNER_GAP + 2);

  localparam logic [CW-1:0] C_PMAX  = CW'(C_PIXELS_PER_LINE);
  localparam logic [CW-1:0] C_START = CW'(C_EDGE_GAP);
  localparam logic [CW-1:0] C_WM1   = CW'(W - 1);
  localparam logic [CW-1:0] C_STEP  = CW'(C_INNER_GAP + 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [2:0]    C_LAST  = 3'(C_NUM_SUBIMAGES - 1);
  localparam logic [3:0]    C_KMAX  = (C_LUMA_WIDTH > 16) ? 4'hf : 4'(C_LUMA_WIDTH - 1);

  generate
    if (C_EDGE_GAP + C_NUM_SUBIMAGES * W + (C_NUM_SUBIMAGES - 1) * C_INNER_GAP > C_PIXELS_PER_LINE) begin : g_bad_geometry
      $error("gcbp_stripe_gen: sub images do not fit in the active line");
    end
    if (C_NUM_SUBIMAGES < 1 || C_NUM_SUBIMAGES > 8) begin : g_bad_count
      $error("gcbp_stripe_gen: C_NUM_SUBIMAGES must be 1..8");
    end
    if (W < 2) begin : g_bad_width
      $error("gcbp_stripe_gen: C_SUBIMAGE_WIDTH must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_CAPTURE,
    S_TAIL
  } state_t;

  state_t          state;
  logic [CW-1:0]   pix_cnt;
  // Pixel index ending the current phase: start_s while in GAP, start_s+W-1 in CAPTURE.
  logic [CW-1:0]   edge_pos;
  logic [2:0]      sub_idx;
  logic [3:0]      k_sel;
  logic            gray_sel;
  logic [W-1:0]    shift_q;
  // Completion is staged one cycle so o_line loads on the edge after the last pixel.
  logic            done_q;
  logic [2:0]      done_idx;

  logic [3:0]      k_clamped;
  logic [1:0]      bit_pair;
  logic            pix_bit;
  logic            pix_take;

  assign k_clamped = (i_bit_plane > C_KMAX) ? C_KMAX : i_bit_plane;
  // A zero above the MSB makes the top plane's gray bit degrade to the plain bit.
  assign bit_pair  = 2'({1'b0, i_luma_data} >> k_sel);
  assign pix_bit   = bit_pair[0] ^ (gray_sel & bit_pair[1]);
  assign pix_take  = i_luma_valid && (state == S_GAP || state == S_CAPTURE) && (pix_cnt != C_PMAX);

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state             <= S_IDLE;
      pix_cnt           <= '0;
      edge_pos          <= '0;
      sub_idx           <= '0;
      k_sel             <= '0;
      gray_sel          <= 1'b0;
      shift_q           <= '0;
      done_q            <= 1'b0;
      done_idx          <= '0;
      o_line            <= '0;
      o_line_valid      <= 1'b0;
      o_subimage_idx    <= '0;
      o_busy            <= 1'b0;
      o_overflow        <= 1'b0;
      o_overflow_sticky <= 1'b0;
    end else begin
      o_overflow <= 1'b0;
      done_q     <= 1'b0;

      // Output holding register; independent of i_new_line so a pending line survives it.
      if (done_q) begin
        o_line         <= shift_q;
        o_subimage_idx <= done_idx;
        o_line_valid   <= 1'b1;
        if (o_line_valid && !i_line_ready) begin
          o_overflow        <= 1'b1;
          o_overflow_sticky <= 1'b1;
        end
      end else if (o_line_valid && i_line_ready) begin
        o_line_valid <= 1'b0;
      end

      if (i_new_line) begin
        state    <= S_GAP;
        o_busy   <= 1'b1;
        pix_cnt  <= '0;
        edge_pos <= C_START;
        sub_idx  <= '0;
        shift_q  <= '0;
        k_sel    <= k_clamped;
        gray_sel <= i_gray_mode;
      end else if (pix_take) begin
        pix_cnt <= pix_cnt + C_ONE;
        case (state)
          S_GAP: begin
            if (pix_cnt == edge_pos) begin
              shift_q  <= {shift_q[W-2:0], pix_bit};
              edge_pos <= edge_pos + C_WM1;
              state    <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            shift_q <= {shift_q[W-2:0], pix_bit};
            if (pix_cnt == edge_pos) begin
              done_q   <= 1'b1;
              done_idx <= sub_idx;
              if (sub_idx == C_LAST) begin
                state  <= S_TAIL;
                o_busy <= 1'b0;
              end else begin
                state    <= S_GAP;
                sub_idx  <= sub_idx + 3'd1;
                edge_pos <= edge_pos + C_STEP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
